// File: rtl/ram_bus_arbiter.sv
// Two-master, one-slave arbiter in front of the on-chip RAM. Read and write
// channels are arbitrated independently, and read data is steered back to its owner.
module ram_bus_arbiter #(
   parameter int unsigned FIXED_PRIO = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             m0_rd_req,
   input  logic [31:0]      m0_rd_addr,
   output logic             m0_rd_gnt,
   output logic [31:0]      m0_rd_data,
   input  logic             m1_rd_req,
   input  logic [31:0]      m1_rd_addr,
   output logic             m1_rd_gnt,
   output logic [31:0]      m1_rd_data,

   input  logic             m0_wr_req,
   input  logic [31:0]      m0_wr_addr,
   input  logic [3:0]       m0_wr_be,
   input  logic [31:0]      m0_wr_data,
   output logic             m0_wr_gnt,
   input  logic             m1_wr_req,
   input  logic [31:0]      m1_wr_addr,
   input  logic [3:0]       m1_wr_be,
   input  logic [31:0]      m1_wr_data,
   output logic             m1_wr_gnt,

   output logic             s_rd_req,
   output logic [31:0]      s_rd_addr,
   input  logic             s_rd_gnt,
   input  logic [31:0]      s_rd_data,
   output logic             s_wr_req,
   output logic [31:0]      s_wr_addr,
   output logic [3:0]       s_wr_be,
   output logic [31:0]      s_wr_data,
   input  logic             s_wr_gnt,

   output logic [CNT_W-1:0] contention_cnt
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic             rd_last_q, rd_last_d;
   logic             wr_last_q, wr_last_d;
   logic             rd_owner_vld_q, rd_owner_vld_d;
   logic             rd_owner_id_q, rd_owner_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             rd_sel;
   logic             wr_sel;
   logic             contend;

   // Master id chosen for one channel; the "last" bit holds the previous winner.
   function automatic logic pick(input logic req0, input logic req1, input logic last);
      logic sel;
      sel = 1'b0;
      if (req0 && req1) begin
         sel = (FIXED_PRIO != 0) ? 1'b0 : ~last;
      end else if (req1) begin
         sel = 1'b1;
      end
      return sel;
   endfunction

   always_comb begin
      rd_sel = pick(m0_rd_req, m1_rd_req, rd_last_q);
      wr_sel = pick(m0_wr_req, m1_wr_req, wr_last_q);
   end

   always_comb begin
      s_rd_req  = m0_rd_req | m1_rd_req;
      s_rd_addr = rd_sel ? m1_rd_addr : m0_rd_addr;
      s_wr_req  = m0_wr_req | m1_wr_req;
      s_wr_addr = wr_sel ? m1_wr_addr : m0_wr_addr;
      s_wr_be   = wr_sel ? m1_wr_be   : m0_wr_be;
      s_wr_data = wr_sel ? m1_wr_data : m0_wr_data;
   end

   always_comb begin
      m0_rd_gnt = ~rd_sel & m0_rd_req & s_rd_gnt;
      m1_rd_gnt =  rd_sel & m1_rd_req & s_rd_gnt;
      m0_wr_gnt = ~wr_sel & m0_wr_req & s_wr_gnt;
      m1_wr_gnt =  wr_sel & m1_wr_req & s_wr_gnt;
   end

   // Returning read data is a plain mux gated by the registered owner tag.
   always_comb begin
      m0_rd_data = (rd_owner_vld_q && !rd_owner_id_q) ? s_rd_data : 32'h0;
      m1_rd_data = (rd_owner_vld_q &&  rd_owner_id_q) ? s_rd_data : 32'h0;
   end

   always_comb begin
      rd_last_d      = rd_last_q;
      wr_last_d      = wr_last_q;
      rd_owner_vld_d = 1'b0;
      rd_owner_id_d  = rd_owner_id_q;
      cnt_d          = cnt_q;
      contend        = (m0_rd_req & m1_rd_req) | (m0_wr_req & m1_wr_req);

      if (s_rd_req && s_rd_gnt) begin
         rd_last_d      = rd_sel;
         rd_owner_vld_d = 1'b1;
         rd_owner_id_d  = rd_sel;
      end
      if (s_wr_req && s_wr_gnt) begin
         wr_last_d = wr_sel;
      end
      if (contend && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CntOne;
      end
   end

   // Last-winner bits reset to m1 so that m0 wins the first contended cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_last_q      <= 1'b1;
         wr_last_q      <= 1'b1;
         rd_owner_vld_q <= 1'b0;
         rd_owner_id_q  <= 1'b0;
         cnt_q          <= '0;
      end else begin
         rd_last_q      <= rd_last_d;
         wr_last_q      <= wr_last_d;
         rd_owner_vld_q <= rd_owner_vld_d;
         rd_owner_id_q  <= rd_owner_id_d;
         cnt_q          <= cnt_d;
      end
   end

   assign contention_cnt = cnt_q;

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Two-master to one-slave arbiter that shares the 4 kB on-chip RAM slave between the instruction-fetch port (m0) and the data port (m1).
- Read and write channels are arbitrated independently, because the RAM has separate read and write ports.
- Read data returns one cycle after grant. The arbiter registers which master owns the returning data and steers it back to that master.
- Sits between the core's two naive_bus master ports and the RAM wrapper's slave port.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin per channel; 1 = m0 always wins on contention.
- CNT_W, 16: width of the saturating contention counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_rd_req / m1_rd_req  in  1  read request, held until granted
- m0_rd_addr / m1_rd_addr  in  32  read byte address
- m0_rd_gnt / m1_rd_gnt  out  1  read grant, same cycle as request
- m0_rd_data / m1_rd_data  out  32  read data, valid the cycle after grant
- m0_wr_req / m1_wr_req  in  1  write request
- m0_wr_addr / m1_wr_addr  in  32  write byte address
- m0_wr_be / m1_wr_be  in  4  byte enables
- m0_wr_data / m1_wr_data  in  32  write data
- m0_wr_gnt / m1_wr_gnt  out  1  write grant
- s_rd_req  out  1  read request to RAM
- s_rd_addr  out  32  read address to RAM
- s_rd_gnt  in  1  RAM read grant
- s_rd_data  in  32  RAM read data, one cycle after s_rd_gnt
- s_wr_req  out  1  write request to RAM
- s_wr_addr  out  32  write address to RAM
- s_wr_be  out  4  byte enables to RAM
- s_wr_data  out  32  write data to RAM
- s_wr_gnt  in  1  RAM write grant
- contention_cnt  out  CNT_W  cycles in which both masters requested the same channel

Behaviour:
- Reset: one clock (clk); reset is asynchronous, active-low (rst_n).
  - rd_last and wr_last reset to 1 (m0 preferred first).
  - rd_owner_vld resets to 0; rd_owner_id resets to 0.
  - contention_cnt resets to 0.
  - m0_rd_data and m1_rd_data read 0 out of reset.
- Select (combinational, per channel):
  - Only one master requesting: select it.
  - Both requesting: select the master != last (round-robin), or m0 if FIXED_PRIO=1.
  - Neither requesting: s_*_req = 0. Address, be and data mux to m0's values.
- Slave request and forwarding: s_X_req = m0_X_req | m1_X_req. Selected master's address, be and data are forwarded.
- Master grant: mK_X_gnt = sel==K & mK_X_req & s_X_gnt. The non-selected master sees gnt=0 and must hold its request.
- Last-grant update: on a clk edge where s_X_gnt & s_X_req, last <= sel. Otherwise last holds.
- Read return:
  - On s_rd_gnt & s_rd_req: rd_owner_vld <= 1 and rd_owner_id <= sel. Otherwise rd_owner_vld <= 0.
  - mK_rd_data = s_rd_data when rd_owner_vld & rd_owner_id==K, else 0.
  - Back-to-back reads from alternating masters return data to the correct owner every cycle.
- Contention counter: increments on each cycle where both masters request the read channel, or both request the write channel (+1 per cycle, not +2). Saturates at all-ones with no wrap.
- Simultaneous read and write:
  - Channels are independent, so m0 read and m1 write (or the reverse) are granted in the same cycle.
  - A same-address read/write in one cycle returns whatever the RAM returns. The arbiter does no forwarding.
- Slave stall (s_X_gnt=0): no master grant, last unchanged, rd_owner_vld <= 0 for the read channel.
- Reset mid-operation: asserting rst_n low clears rd_owner_vld immediately, so an in-flight read's data is dropped and both rd_data outputs go to 0. Arbitration restarts with m0 preferred.
- Latency: zero added cycles on the request path. Read data is a straight mux of s_rd_data, one cycle after grant.

Test Plan:
- Reset, then m1_rd_req only, addr 0x10 -> m1_rd_gnt=1 same cycle. Next cycle m1_rd_data = RAM[0x10] and m0_rd_data = 0.
- Both masters read every cycle (m0 addr 0x0, m1 addr 0x4), RAM preloaded 0xAAAA0000 / 0xBBBB0004 -> grants alternate m0, m1, m0, …; each master receives only its own word, one cycle after its grant; contention_cnt increments by 1 per cycle.
- Same-cycle m0 read 0x8 and m1 write 0xC, be=4'b0011, data 0x12345678 -> both granted. A later read of 0xC returns low half 0x5678 with the upper bytes unchanged.
- FIXED_PRIO=1, both masters write continuously -> m0_wr_gnt=1 every cycle, m1_wr_gnt never asserts.
- Tie s_rd_gnt=0 for 3 cycles while both masters request -> no master grants, rd_data = 0, last unchanged. Release -> grant goes to m0 (last=1 from reset).
- Assert rst_n low the cycle after an m1 read grant -> m1_rd_data = 0 immediately. After release: contention_cnt=0 and the first contended grant goes to m0.
- Force 2^CNT_W-1 contention cycles (CNT_W=4 build, 15 cycles) plus 3 more -> contention_cnt holds at 0xF.
